// File: rtl/bus_responder.sv
// Asynchronous-bus slave with a 2^ADDR_BITS x 16 RAM, programmable wait states and
// byte-lane writes. DTACK is registered and follows ACK entry by one clock.
module bus_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter logic [22:0] BASE        = 23'h000000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:1] A,
  input  logic        AS,
  input  logic        UDS,
  input  logic        LDS,
  input  logic        RW,
  inout  wire  [15:0] D,
  output logic        DTACK
);

  localparam logic [3:0] WaitInit = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic [ADDR_BITS-1:0]   addr_lat;
  logic                   rw_lat;
  logic                   uds_lat;
  logic                   lds_lat;
  logic                   drive;
  logic [15:0]            rd_data;
  logic [15:0]            mem [0:(2**ADDR_BITS)-1];

  logic                   sel;
  logic                   ack_entry;
  logic [ADDR_BITS-1:0]   acc_addr;
  logic                   acc_rw;
  logic                   acc_uds;
  logic                   acc_lds;

  assign sel = !AS && (!UDS || !LDS) && (A[23:ADDR_BITS+1] == BASE[22:ADDR_BITS]);
  assign D   = drive ? rd_data : 16'bz;

  // RAM access happens on the edge that enters ACK; with no wait states that edge
  // is the select edge itself, so the live bus fields are used instead of the latches.
  always_comb begin
    ack_entry = 1'b0;
    acc_addr  = addr_lat;
    acc_rw    = rw_lat;
    acc_uds   = uds_lat;
    acc_lds   = lds_lat;
    if (!RESET) begin
      unique case (state)
        StIdle: begin
          if (sel && (WAIT_STATES == 0)) begin
            ack_entry = 1'b1;
            acc_addr  = A[ADDR_BITS:1];
            acc_rw    = RW;
            acc_uds   = UDS;
            acc_lds   = LDS;
          end
        end
        StWait:  ack_entry = !AS && (cnt == 4'd0);
        default: ack_entry = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= StIdle;
      cnt      <= 4'd0;
      addr_lat <= '0;
      rw_lat   <= 1'b0;
      uds_lat  <= 1'b0;
      lds_lat  <= 1'b0;
      drive    <= 1'b0;
      DTACK    <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          if (sel) begin
            addr_lat <= A[ADDR_BITS:1];
            rw_lat   <= RW;
            uds_lat  <= UDS;
            lds_lat  <= LDS;
            if (WAIT_STATES == 0) begin
              state <= StAck;
              drive <= RW;
            end else begin
              state <= StWait;
              cnt   <= WaitInit;
            end
          end
        end
        StWait: begin
          if (AS) begin
            state <= StIdle;
            cnt   <= 4'd0;
          end else if (cnt == 4'd0) begin
            state <= StAck;
            drive <= rw_lat;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        StAck: begin
          if (AS) begin
            state <= StIdle;
            DTACK <= 1'b1;
            drive <= 1'b0;
          end else begin
            DTACK <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          DTACK <= 1'b1;
          drive <= 1'b0;
        end
      endcase
    end
  end

  // RAM is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (ack_entry) begin
      if (acc_rw) begin
        rd_data <= mem[acc_addr];
      end else begin
        if (!acc_uds) mem[acc_addr][15:8] <= D[15:8];
        if (!acc_lds) mem[acc_addr][7:0]  <= D[7:0];
      end
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench: one responder with two wait states and one with none; D has a pullup
// so an undriven bus reads as 16'hFFFF.
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:1] a = '0;
  logic        as_n = 1'b1;
  logic        as0_n = 1'b1;
  logic        uds_n = 1'b1;
  logic        lds_n = 1'b1;
  logic        rw = 1'b1;
  logic [15:0] d_drv = '0;
  logic        d_oe = 1'b0;
  logic        d0_oe = 1'b0;
  wire  [15:0] d;
  wire  [15:0] d0;
  logic        dtack;
  logic        dtack0;

  int n_chk = 0;
  int n_pass = 0;

  assign d  = d_oe  ? d_drv : 16'bz;
  assign d0 = d0_oe ? d_drv : 16'bz;
  pullup (d);
  pullup (d0);

  always #5 clk = ~clk;

  bus_responder #(.ADDR_BITS(10), .BASE(23'h000000), .WAIT_STATES(2)) dut (
    .CLK(clk), .RESET(rst), .A(a), .AS(as_n), .UDS(uds_n), .LDS(lds_n), .RW(rw),
    .D(d), .DTACK(dtack)
  );

  bus_responder #(.ADDR_BITS(10), .BASE(23'h000000), .WAIT_STATES(0)) dut0 (
    .CLK(clk), .RESET(rst), .A(a), .AS(as0_n), .UDS(uds_n), .LDS(lds_n), .RW(rw),
    .D(d0), .DTACK(dtack0)
  );

  typedef struct {
    logic        rw;
    logic [22:0] addr;
    logic        uds;
    logic        lds;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One full bus cycle on either responder; latency counted in posedges after the select edge.
  task automatic bus_cycle(input bit alt, input logic wr_rw, input logic [22:0] addr,
                           input logic u, input logic l, input logic [15:0] wdata,
                           input logic [15:0] exp_rd, input int exp_lat, input string name);
    int          lat;
    logic        dt;
    logic [15:0] rd;
    @(negedge clk);
    a = addr; rw = wr_rw; uds_n = u; lds_n = l; d_drv = wdata;
    if (alt) begin as0_n = 1'b0; d0_oe = !wr_rw; end
    else     begin as_n  = 1'b0; d_oe  = !wr_rw; end
    @(posedge clk);
    lat = 0;
    dt  = 1'b1;
    while (dt && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      dt = alt ? dtack0 : dtack;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    rd = alt ? d0 : d;
    if (wr_rw) chk({name, " read data"}, {16'h0, rd}, {16'h0, exp_rd});
    @(negedge clk);
    as_n = 1'b1; as0_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; d_oe = 1'b0; d0_oe = 1'b0;
    @(posedge clk);
    #1;
    chk({name, " dtack release"}, {31'h0, alt ? dtack0 : dtack}, 32'h1);
    chk({name, " bus release"}, {16'h0, alt ? d0 : d}, 32'h0000_FFFF);
  endtask

  initial begin
    int lat;
    vecs[0] = '{1'b0, 23'h005, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 3};
    vecs[1] = '{1'b1, 23'h005, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 3};
    vecs[2] = '{1'b0, 23'h010, 1'b0, 1'b0, 16'h1234, 16'h0000, 3};
    vecs[3] = '{1'b0, 23'h010, 1'b0, 1'b1, 16'hAB00, 16'h0000, 3};
    vecs[4] = '{1'b1, 23'h010, 1'b0, 1'b0, 16'h0000, 16'hAB34, 3};
    vecs[5] = '{1'b0, 23'h010, 1'b1, 1'b0, 16'h00CD, 16'h0000, 3};
    vecs[6] = '{1'b1, 23'h010, 1'b1, 1'b1 ^ 1'b1, 16'h0000, 16'hABCD, 3};
    vecs[7] = '{1'b0, 23'h020, 1'b0, 1'b0, 16'h1111, 16'h0000, 3};
    vecs[8] = '{1'b0, 23'h3FF, 1'b0, 1'b0, 16'hA5C3, 16'h0000, 3};
    vecs[9] = '{1'b1, 23'h3FF, 1'b1, 1'b0, 16'h0000, 16'hA5C3, 3};

    repeat (2) @(posedge clk);
    #1;
    chk("reset dtack", {31'h0, dtack}, 32'h1);
    chk("reset bus", {16'h0, d}, 32'h0000_FFFF);
    chk("reset dtack ws0", {31'h0, dtack0}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      bus_cycle(1'b0, vecs[i].rw, vecs[i].addr, vecs[i].uds, vecs[i].lds, vecs[i].wdata,
                vecs[i].exp_rd, vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // Both strobes high is not a select.
    @(negedge clk);
    a = 23'h005; rw = 1'b1; uds_n = 1'b1; lds_n = 1'b1; as_n = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("no strobe dtack", {31'h0, dtack}, 32'h1);
    end
    @(negedge clk); as_n = 1'b1;

    // Out-of-range address held for 10 cycles.
    @(negedge clk);
    a = 23'h000400; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("out of range dtack", {31'h0, dtack}, 32'h1);
      chk("out of range bus", {16'h0, d}, 32'h0000_FFFF);
    end
    @(negedge clk); as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;

    // Write aborted by AS rising after one WAIT cycle.
    @(negedge clk);
    a = 23'h020; rw = 1'b0; uds_n = 1'b0; lds_n = 1'b0; d_drv = 16'h5555; d_oe = 1'b1;
    as_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; d_oe = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort dtack", {31'h0, dtack}, 32'h1);
    end
    bus_cycle(1'b0, 1'b1, 23'h020, 1'b0, 1'b0, 16'h0, 16'h1111, 3, "after abort");

    // Reset during WAIT of a write must not touch RAM.
    @(negedge clk);
    a = 23'h020; rw = 1'b0; uds_n = 1'b0; lds_n = 1'b0; d_drv = 16'h7777; d_oe = 1'b1;
    as_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; d_oe = 1'b0;
    bus_cycle(1'b0, 1'b1, 23'h020, 1'b0, 1'b0, 16'h0, 16'h1111, 3, "after wait reset");

    // Reset pulse during ACK of a read releases DTACK and D before the next edge.
    @(negedge clk);
    a = 23'h005; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    @(posedge clk);
    lat = 0;
    while (dtack && lat < 20) begin
      @(posedge clk); lat++; #1;
    end
    chk("ack reset latency", 32'(lat), 32'd3);
    @(negedge clk);
    #1 rst = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    #1;
    chk("ack reset dtack", {31'h0, dtack}, 32'h1);
    chk("ack reset bus", {16'h0, d}, 32'h0000_FFFF);
    #1 rst = 1'b0;
    bus_cycle(1'b0, 1'b1, 23'h005, 1'b0, 1'b0, 16'h0, 16'hBEEF, 3, "after ack reset");

    // Zero wait states: write then two reads with a single AS-high cycle between them.
    bus_cycle(1'b1, 1'b0, 23'h007, 1'b0, 1'b0, 16'h1357, 16'h0, 1, "ws0 write");
    bus_cycle(1'b1, 1'b1, 23'h007, 1'b0, 1'b0, 16'h0, 16'h1357, 1, "ws0 read1");
    bus_cycle(1'b1, 1'b1, 23'h007, 1'b1, 1'b0, 16'h0, 16'h1357, 1, "ws0 read2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
